td4_prog_loader: RTL

//  Loadable program store for the TD4 core, directly upstream of the CPU. It

---
 rtl/td4_prog_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/td4_prog_loader.sv
// Loadable 16x8 program store for the TD4 core: receives framed programs over a
// byte stream, verifies the checksum and holds the CPU in clear until a good load.
module td4_prog_loader #(
   parameter int TIMEOUT = 255
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic [7:0] InData,
   input  logic       InValid,
   output logic       InReady,
   input  logic [3:0] Address,
   output logic [7:0] Order,
   output logic       CpuClr,
   output logic       Busy,
   output logic       Done,
   output logic       Error
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_CSUM  = 3'd3,
      ST_CHECK = 3'd4
   } state_t;

   localparam logic [7:0]  SYNC_BYTE = 8'hA5;
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

   function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

   state_t      state_r, state_s;
   logic [7:0]  mem_r [16];
   logic        done_r, done_s;
   logic        error_r, error_s;
   logic        cpuclr_r, cpuclr_s;
   logic [3:0]  idx_r, idx_s;
   logic [4:0]  len_r, len_s;
   logic [7:0]  sum_r, sum_s;
   logic [7:0]  csum_r, csum_s;
   logic [15:0] tmo_r, tmo_s;
   logic        we_s;
   logic        xfer_s;
   logic        tmo_hit_s;

   assign InReady   = (state_r != ST_CHECK);
   assign Busy      = (state_r != ST_IDLE);
   assign Done      = done_r;
   assign Error     = error_r;
   assign CpuClr    = cpuclr_r;
   assign Order     = mem_r[Address];
   assign xfer_s    = InValid & InReady;
   assign tmo_hit_s = (tmo_r == TMO_LAST);

   // Next-state and next-register computation for the frame parser.
   always_comb begin
      state_s  = state_r;
      done_s   = done_r;
      error_s  = error_r;
      cpuclr_s = cpuclr_r;
      idx_s    = idx_r;
      len_s    = len_r;
      sum_s    = sum_r;
      csum_s   = csum_r;
      tmo_s    = tmo_r;
      we_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s && (InData == SYNC_BYTE)) begin
               state_s  = ST_LEN;
               done_s   = 1'b0;
               error_s  = 1'b0;
               cpuclr_s = 1'b0;
               sum_s    = 8'h00;
               tmo_s    = 16'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LEN: begin
            if (xfer_s) begin
               tmo_s = 16'd0;
               if ((InData >= 8'd1) && (InData <= 8'd16)) begin
                  state_s = ST_DATA;
                  sum_s   = InData;
                  idx_s   = 4'd0;
                  len_s   = InData[4:0];
               end else begin
                  state_s = ST_IDLE;
                  error_s = 1'b1;
               end
            end else if (tmo_hit_s) begin
               state_s = ST_IDLE;
               error_s = 1'b1;
               tmo_s   = 16'd0;
            end else begin
               tmo_s = tmo_r + 16'd1;
            end
         end
         ST_DATA: begin
            if (xfer_s) begin
               we_s  = 1'b1;
               sum_s = add8(sum_r, InData);
               idx_s = idx_r + 4'd1;
               tmo_s = 16'd0;
               // 0xA5 here is ordinary payload; only the length ends the data phase
               if ({1'b0, idx_r} == (len_r - 5'd1)) begin
                  state_s = ST_CSUM;
               end else begin
                  state_s = ST_DATA;
               end
            end else if (tmo_hit_s) begin
               state_s = ST_IDLE;
               error_s = 1'b1;
               tmo_s   = 16'd0;
            end else begin
               tmo_s = tmo_r + 16'd1;
            end
         end
         ST_CSUM: begin
            if (xfer_s) begin
               csum_s  = InData;
               state_s = ST_CHECK;
               tmo_s   = 16'd0;
            end else if (tmo_hit_s) begin
               state_s = ST_IDLE;
               error_s = 1'b1;
               tmo_s   = 16'd0;
            end else begin
               tmo_s = tmo_r + 16'd1;
            end
         end
         ST_CHECK: begin
            state_s = ST_IDLE;
            if (csum_r == sum_r) begin
               done_s   = 1'b1;
               cpuclr_s = 1'b1;
            end else begin
               error_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_r  <= ST_IDLE;
         done_r   <= 1'b0;
         error_r  <= 1'b0;
         cpuclr_r <= 1'b0;
         idx_r    <= 4'd0;
         len_r    <= 5'd0;
         sum_r    <= 8'h00;
         csum_r   <= 8'h00;
         tmo_r    <= 16'd0;
      end else begin
         state_r  <= state_s;
         done_r   <= done_s;
         error_r  <= error_s;
         cpuclr_r <= cpuclr_s;
         idx_r    <= idx_s;
         len_r    <= len_s;
         sum_r    <= sum_s;
         csum_r   <= csum_s;
         tmo_r    <= tmo_s;
      end
   end

   // Program memory; cleared by reset so a half-loaded program never survives.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int i = 0; i < 16; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else if (we_s) begin
         mem_r[idx_r] <= InData;
      end
   end

endmodule
